// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access-size encodings, FSM states,
// and the alignment predicate used by the optional misalignment trap.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE     = 2'b00;
    localparam logic [1:0] SZ_HALF     = 2'b01;
    localparam logic [1:0] SZ_WORD     = 2'b10;
    localparam logic [1:0] SZ_WORD_ALT = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        DONE
    } lsu_state_e;

    // Both word encodings share the high bit.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        if (size[1])
            return lo != 2'b00;
        else if (size == SZ_HALF)
            return lo[0];
        else
            return 1'b0;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: little-endian load extract/extend and
// sub-word store merge into the current memory word.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [4:0]  bit_off;

    always_comb begin
        bit_off = {addr_lo, 3'b000};
        lane_b  = rdata[bit_off +: 8];
        lane_h  = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        load_data = rdata;
        case (size)
            SZ_BYTE: load_data = {{24{~is_unsigned & lane_b[7]}}, lane_b};
            SZ_HALF: load_data = {{16{~is_unsigned & lane_h[15]}}, lane_h};
            default: load_data = rdata;
        endcase

        // Half-word lane ignores addr_lo[0]; word ignores both low bits.
        merge_data = rdata;
        case (size)
            SZ_BYTE: merge_data[bit_off +: 8] = wdata[7:0];
            SZ_HALF: begin
                if (addr_lo[1])
                    merge_data[31:16] = wdata[15:0];
                else
                    merge_data[15:0]  = wdata[15:0];
            end
            default: merge_data = wdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time, read-modify-write for sub-word
// stores. Define LSU_MISALIGN_TRAP_EN to flag misaligned half/word accesses.
module lsu
    import lsu_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [DEPTH_LOG2-1:0] dm_addr,
    output logic                  dm_ctrl_w,
    output logic                  dm_ctrl_r,
    output logic [31:0]           dm_wdata,
    input  logic [31:0]           dm_rdata
);

    lsu_state_e  state;
    logic [1:0]  size_q;
    logic [1:0]  lo_q;
    logic        we_q;
    logic        uns_q;
    logic [31:0] wdata_q;
    logic [31:0] load_data;
    logic [31:0] merge_data;
    logic        trap;

    // Address bits above the memory window wrap around.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:DEPTH_LOG2+2];

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = misaligned(req_size, req_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    assign req_ready = (state == IDLE);

    lsu_align u_align (
        .size        (size_q),
        .addr_lo     (lo_q),
        .is_unsigned (uns_q),
        .rdata       (dm_rdata),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merge_data  (merge_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            size_q     <= SZ_BYTE;
            lo_q       <= 2'b00;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            wdata_q    <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            dm_addr    <= '0;
            dm_ctrl_w  <= 1'b0;
            dm_ctrl_r  <= 1'b0;
            dm_wdata   <= '0;
        end else begin
            resp_valid <= 1'b0;
            dm_ctrl_r  <= 1'b0;
            dm_ctrl_w  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        size_q     <= req_size;
                        lo_q       <= req_addr[1:0];
                        we_q       <= req_we;
                        uns_q      <= req_unsigned;
                        wdata_q    <= req_wdata;
                        dm_addr    <= req_addr[DEPTH_LOG2+1:2];
                        dm_wdata   <= req_wdata;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                        if (trap) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (req_we && is_word(req_size)) begin
                            state     <= WR;
                            dm_ctrl_w <= 1'b1;
                        end else begin
                            state     <= RD;
                            dm_ctrl_r <= 1'b1;
                        end
                    end
                end
                RD: state <= CAP;
                CAP: begin
                    // dm_rdata carries the word read during RD.
                    if (we_q) begin
                        dm_wdata  <= merge_data;
                        dm_ctrl_w <= 1'b1;
                        state     <= WR;
                    end else begin
                        resp_rdata <= load_data;
                        resp_valid <= 1'b1;
                        state      <= DONE;
                    end
                end
                WR: begin
                    resp_valid <= 1'b1;
                    state      <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Randomized self-checking bench for lsu against a byte-array memory model.
module tb_lsu;

    localparam int DL    = 8;
    localparam int DEPTH = 1 << DL;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]    req_size;
    logic [31:0]   req_addr, req_wdata;
    logic          resp_valid, resp_err;
    logic [31:0]   resp_rdata;
    logic [DL-1:0] dm_addr;
    logic          dm_ctrl_w, dm_ctrl_r;
    logic [31:0]   dm_wdata, dm_rdata;

    logic [31:0]   mem [0:DEPTH-1];
    logic [7:0]    ref_b [0:4*DEPTH-1];
    logic          pl_en = 1'b0;
    logic [DL-1:0] pl_idx = '0;
    logic [31:0]   pl_val = '0;
    int            wr_cnt = 0, rd_cnt = 0;
    int            checks = 0, errors = 0;
    logic [31:0]   last_rdata;
    logic          last_err;
    int            last_lat;

    always #5 clk = ~clk;

    lsu #(.DEPTH_LOG2(DL)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .dm_addr(dm_addr),
        .dm_ctrl_w(dm_ctrl_w), .dm_ctrl_r(dm_ctrl_r), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata)
    );

    // Synchronous memory: read data appears the cycle after dm_ctrl_r.
    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_val;
        else if (dm_ctrl_w) mem[dm_addr] <= dm_wdata;
        if (dm_ctrl_r) dm_rdata <= mem[dm_addr];
        if (dm_ctrl_w) wr_cnt <= wr_cnt + 1;
        if (dm_ctrl_r) rd_cnt <= rd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int idx);
        return {ref_b[4*idx+3], ref_b[4*idx+2], ref_b[4*idx+1], ref_b[4*idx]};
    endfunction

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        pl_en = 1'b1; pl_idx = DL'(idx); pl_val = val;
        @(posedge clk); #1;
        pl_en = 1'b0;
        for (int i = 0; i < 4; i++) ref_b[4*idx+i] = val[8*i +: 8];
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("ready_timeout", 32'(req_ready), 32'd1);
    endtask

    task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
        int widx, base, lane, nb, exp_lat, lat, w0, r0;
        logic mis, trap_on, exp_wr, exp_rd;
        logic [31:0] v;
`ifdef LSU_MISALIGN_TRAP_EN
        trap_on = 1'b1;
`else
        trap_on = 1'b0;
`endif
        widx = int'(addr[DL+1:2]);
        base = 4 * widx;
        nb   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        lane = (nb == 1) ? int'(addr[1:0]) : (nb == 2) ? 2 * int'(addr[1]) : 0;
        mis  = (nb == 2 && addr[0]) || (nb == 4 && addr[1:0] != 2'b00);
        mis  = mis && trap_on;
        v = '0;
        if (!mis) begin
            if (we) begin
                for (int i = 0; i < nb; i++) ref_b[base+lane+i] = wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < nb; i++) v = v | (32'(ref_b[base+lane+i]) << (8*i));
                if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
            end
        end
        exp_lat = mis ? 0 : (we && nb == 4) ? 1 : we ? 3 : 2;
        exp_wr  = !mis && we;
        exp_rd  = !mis && !(we && nb == 4);

        wait_ready();
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        w0 = wr_cnt; r0 = rd_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = $urandom_range(1); req_size = 2'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        chk("ctl_first", 32'({dm_ctrl_w, dm_ctrl_r}),
            32'(mis ? 2'b00 : (exp_lat == 1) ? 2'b10 : 2'b01));
        if (!mis) chk("dm_addr", 32'(dm_addr), 32'(widx));
        lat = 0;
        while (!resp_valid && lat < 8) begin @(posedge clk); #1; lat++; end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("rdata", resp_rdata, v);
        chk("err", 32'(resp_err), 32'(mis));
        last_rdata = resp_rdata; last_err = resp_err; last_lat = lat;
        @(posedge clk); #1;
        chk("pulse", 32'(resp_valid), 32'd0);
        chk("writes", 32'(wr_cnt - w0), 32'(exp_wr));
        chk("reads", 32'(rd_cnt - r0), 32'(exp_rd));
        chk("mem", mem[widx], ref_word(widx));
    endtask

    initial begin
        int w0;
        logic [31:0] a;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        for (int i = 0; i < 4*DEPTH; i++) ref_b[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_outs", 32'({resp_valid, resp_err, dm_ctrl_w, dm_ctrl_r}), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_wdata", dm_wdata, 32'd0);
        chk("rst_addr", 32'(dm_addr), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) preload(i, $urandom);

        // Word store: write strobe one cycle after accept, response next.
        run_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        chk("sw_mem4", mem[4], 32'hDEAD_BEEF);
        chk("sw_lat", 32'(last_lat), 32'd1);

        preload(4, 32'h8081_7F01);
        run_req(1'b0, 2'b00, 1'b0, 32'h12, 32'h0);
        chk("lb_data", last_rdata, 32'hFFFF_FF81);
        chk("lb_lat", 32'(last_lat), 32'd2);
        run_req(1'b0, 2'b00, 1'b1, 32'h12, 32'h0);
        chk("lbu_data", last_rdata, 32'h0000_0081);

        preload(4, 32'hDEAD_BEEF);
        run_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_1234);
        chk("sh_mem4", mem[4], 32'h1234_BEEF);
        chk("sh_lat", 32'(last_lat), 32'd3);

        preload(0, 32'hCAFE_F00D);
        run_req(1'b0, 2'b10, 1'b0, 32'h401, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lw_mis_err", 32'(last_err), 32'd1);
        chk("lw_mis_data", last_rdata, 32'd0);
`else
        chk("lw_wrap_data", last_rdata, 32'hCAFE_F00D);
`endif

        // Reset while a sub-word store sits in RD drops it silently.
        wait_ready();
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h13;
        req_wdata = 32'hAA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rst_mid_rd", 32'(dm_ctrl_r), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        w0 = wr_cnt;
        chk("rst_mid_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("rst_mid_quiet", 32'({dm_ctrl_w, resp_valid}), 32'd0);
            @(posedge clk); #1;
        end
        chk("rst_mid_writes", 32'(wr_cnt - w0), 32'd0);
        chk("rst_mid_mem", mem[4], ref_word(4));

        for (int n = 0; n < 300; n++) begin
            a = $urandom;
            if ($urandom_range(1) == 1) a = a & 32'h0000_003F;
            run_req(1'($urandom_range(1)), 2'($urandom), 1'($urandom_range(1)), a, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
